parking_display_ctrl: RTL and testbench

- Occupancy controller and display sequencer for the parking slot system, sitting directly upstream of the 7-segment letter decoder.
- Counts cars from entry/exit sensors and tracks full/open status.
- Time-multiplexes a 4-letter message ("FULL" or "OPEN") onto one shared 4-bit letter code plus active-low digit enables.
- Letter codes: 0=L, 1=U, 2=F, 3=O, 4=P, 5=E, 6=N.

---
 rtl/parking_display_ctrl.sv | 161 ++++++++++++++++
 tb/tb_parking_display_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/parking_display_ctrl.sv
// Parking occupancy counter with synchronized entry/exit sensors and a
// four-digit "FULL"/"OPEN" scan sequencer driving a shared letter code.
module parking_display_ctrl #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4,
    parameter int SCAN_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             car_in,
    input  logic             car_out,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             reject,
    output logic [3:0]       display,
    output logic [3:0]       an
);

    localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(CAPACITY);
    localparam int               DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        DIG3 = 2'd0,
        DIG2 = 2'd1,
        DIG1 = 2'd2,
        DIG0 = 2'd3
    } dig_t;

    // Sensor synchronizers plus a previous-value flop for edge detection
    logic in_s1, in_s2, in_prev;
    logic out_s1, out_s2, out_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_s1    <= 1'b0;
            in_s2    <= 1'b0;
            in_prev  <= 1'b0;
            out_s1   <= 1'b0;
            out_s2   <= 1'b0;
            out_prev <= 1'b0;
        end else begin
            in_s1    <= car_in;
            in_s2    <= in_s1;
            in_prev  <= in_s2;
            out_s1   <= car_out;
            out_s2   <= out_s1;
            out_prev <= out_s2;
        end
    end

    logic ev_in, ev_out;
    assign ev_in  = in_s2 & ~in_prev;
    assign ev_out = out_s2 & ~out_prev;

    // Exit is applied first so a simultaneous exit frees a slot for the entry
    logic [CNT_W-1:0] post_exit;
    logic             entry_ok;
    logic [CNT_W-1:0] count_nxt;
    logic             reject_nxt;

    always_comb begin
        post_exit  = count;
        entry_ok   = 1'b0;
        count_nxt  = count;
        reject_nxt = 1'b0;
        if (ev_out && (count != '0)) begin
            post_exit = count - 1'b1;
        end
        if (ev_in) begin
            if (post_exit < CAP_C) begin
                entry_ok = 1'b1;
            end else begin
                reject_nxt = 1'b1;
            end
        end
        count_nxt = entry_ok ? (post_exit + 1'b1) : post_exit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            reject <= 1'b0;
        end else begin
            count  <= count_nxt;
            reject <= reject_nxt;
        end
    end

    assign full = (count == CAP_C);

    function automatic logic [3:0] letter(input dig_t d, input logic msg);
        logic [3:0] code;
        code = 4'd3;
        case (d)
            DIG3:    code = msg ? 4'd2 : 4'd3;
            DIG2:    code = msg ? 4'd1 : 4'd4;
            DIG1:    code = msg ? 4'd0 : 4'd5;
            DIG0:    code = msg ? 4'd0 : 4'd6;
            default: code = 4'd3;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] enable(input dig_t d);
        logic [3:0] e;
        e = 4'b0111;
        case (d)
            DIG3:    e = 4'b0111;
            DIG2:    e = 4'b1011;
            DIG1:    e = 4'b1101;
            DIG0:    e = 4'b1110;
            default: e = 4'b0111;
        endcase
        return e;
    endfunction

    dig_t             state, state_nxt;
    logic [DIV_W-1:0] div, div_nxt;
    logic             msg_full, msg_nxt;
    logic [3:0]       an_nxt, display_nxt;

    // Message is latched only when a new frame starts at DIG3
    always_comb begin
        state_nxt   = state;
        div_nxt     = div + 1'b1;
        msg_nxt     = msg_full;
        if (div == DIV_LAST) begin
            div_nxt = '0;
            case (state)
                DIG3:    state_nxt = DIG2;
                DIG2:    state_nxt = DIG1;
                DIG1:    state_nxt = DIG0;
                DIG0:    state_nxt = DIG3;
                default: state_nxt = DIG3;
            endcase
            if (state == DIG0) begin
                msg_nxt = full;
            end
        end
        an_nxt      = enable(state_nxt);
        display_nxt = letter(state_nxt, msg_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DIG3;
            div      <= '0;
            msg_full <= 1'b0;
            an       <= 4'b0111;
            display  <= 4'd3;
        end else begin
            state    <= state_nxt;
            div      <= div_nxt;
            msg_full <= msg_nxt;
            an       <= an_nxt;
            display  <= display_nxt;
        end
    end

endmodule

// File: tb/tb_parking_display_ctrl.sv
// Self-checking bench for parking_display_ctrl: a per-cycle reference model
// feeds an expected queue, plus directed checks on occupancy and rejects.
module tb_parking_display_ctrl;

    localparam int CAP   = 8;
    localparam int CW    = 4;
    localparam int SD    = 4;
    localparam int FRAME = 4 * SD;
    localparam int W     = 14;

    logic          clk;
    logic          rst;
    logic          car_in;
    logic          car_out;
    logic [CW-1:0] count;
    logic          full;
    logic          reject;
    logic [3:0]    display;
    logic [3:0]    an;

    parking_display_ctrl #(.CAPACITY(CAP), .CNT_W(CW), .SCAN_DIV(SD)) dut (
        .clk     (clk),
        .rst     (rst),
        .car_in  (car_in),
        .car_out (car_out),
        .count   (count),
        .full    (full),
        .reject  (reject),
        .display (display),
        .an      (an)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rej_cnt = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model, updated on each rising edge
    int   m_count, m_tick;
    logic m_reject, m_msg;
    logic mi1, mi2, mip, mo1, mo2, mop;
    int   open_codes[4] = '{3, 4, 5, 6};
    int   full_codes[4] = '{2, 1, 0, 0};
    logic [3:0] an_codes[4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    always @(posedge clk) begin
        logic ei, eo, pre_full;
        int   dig, c;
        logic [3:0] disp_e;
        if (rst) begin
            m_count = 0; m_reject = 0; m_msg = 0; m_tick = 0;
            mi1 = 0; mi2 = 0; mip = 0; mo1 = 0; mo2 = 0; mop = 0;
        end else begin
            ei = mi2 & ~mip;
            eo = mo2 & ~mop;
            pre_full = (m_count == CAP);
            c = m_count;
            if (eo && c > 0) c = c - 1;
            m_reject = 0;
            if (ei) begin
                if (c < CAP) c = c + 1;
                else m_reject = 1;
            end
            m_count = c;
            mip = mi2; mi2 = mi1; mi1 = car_in;
            mop = mo2; mo2 = mo1; mo1 = car_out;
            m_tick++;
            if (m_tick % FRAME == 0) m_msg = pre_full;
        end
        dig = (m_tick / SD) % 4;
        disp_e = m_msg ? 4'(full_codes[dig]) : 4'(open_codes[dig]);
        exp_q.push_back({CW'(m_count), (m_count == CAP), m_reject, an_codes[dig], disp_e});
    end

    // scoreboard: compare DUT against the oldest expected entry
    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("sb_cycle", {18'd0, count, full, reject, an, display}, {18'd0, e});
        end
        if (reject === 1'b1) rej_cnt++;
    end

    // driver tasks (always called at a falling edge)
    task automatic drive(input logic ci, input logic co, input int cycles);
        car_in  = ci;
        car_out = co;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulse(input logic ci, input logic co);
        drive(ci, co, 3);
        drive(1'b0, 1'b0, 3);
    endtask

    task automatic pulses(input logic ci, input logic co, input int n);
        for (int i = 0; i < n; i++) pulse(ci, co);
    endtask

    initial begin
        rst = 1'b1; car_in = 1'b0; car_out = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        drive(0, 0, 32);
        check("idle_count", 32'(count), 0);
        check("idle_full", 32'(full), 0);

        for (int i = 1; i <= CAP; i++) begin
            pulse(1, 0);
            check("fill_count", 32'(count), 32'(i));
        end
        check("fill_full", 32'(full), 1);
        drive(0, 0, 2 * FRAME);

        rej_cnt = 0;
        pulse(1, 0);
        drive(0, 0, 4);
        check("reject_pulses", 32'(rej_cnt), 1);
        check("reject_count", 32'(count), 8);
        check("reject_disp_full", 32'(full), 1);

        pulses(0, 1, CAP);
        check("drain_count", 32'(count), 0);
        rej_cnt = 0;
        pulse(0, 1);
        check("empty_exit_count", 32'(count), 0);
        check("empty_exit_reject", 32'(rej_cnt), 0);
        drive(1, 0, 20);
        drive(0, 0, 3);
        check("held_in_count", 32'(count), 1);

        pulses(1, 0, 2);
        pulse(1, 1);
        check("both_at3", 32'(count), 3);
        check("both_at3_rej", 32'(rej_cnt), 0);
        pulses(1, 0, 5);
        pulse(1, 1);
        check("both_at8", 32'(count), 8);
        check("both_at8_rej", 32'(rej_cnt), 0);
        pulses(0, 1, CAP);
        pulse(1, 1);
        check("both_at0", 32'(count), 1);

        pulses(1, 0, CAP - 1);
        check("pre_rst_full", 32'(full), 1);
        drive(0, 0, 2 * FRAME + SD + 2);
        rst = 1'b1;
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_an", 32'(an), 32'b0111);
        check("rst_display", 32'(display), 3);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 2 * FRAME);
        check("post_rst_count", 32'(count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
